// File: rtl/lightcube_pkg.sv
// Shared constants and types for the light-cube datapath.
// Holds the frame size, default sync byte and the frame_loader state encoding.
package lightcube_pkg;

  localparam int unsigned FRAME_BYTES = 64;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StCommit
  } fl_state_e;

endpackage

// File: rtl/frame_loader_timer.sv
// Saturating inter-byte timeout counter for frame_loader.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module frame_loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == Limit);

endmodule

// File: rtl/frame_loader.sv
// Sync-hunting byte-stream loader with atomic back-to-front frame commit.
// Define FRAME_LOADER_CHECKSUM_EN to require a modulo-256 checksum byte after the data.
module frame_loader
  import lightcube_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] frame_cube_flat,
  output logic         frame_done,
  output logic         frame_err,
  output logic [7:0]   frame_cnt
);

  fl_state_e  state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] back_q  [FRAME_BYTES];
  logic [7:0] back_d  [FRAME_BYTES];
  logic [7:0] front_q [FRAME_BYTES];
  logic [7:0] front_d [FRAME_BYTES];
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       run_q;
`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic xfer;
  logic expired;

  // run_q keeps in_ready low while in reset and through the first edge after it.
  assign in_ready = run_q && (state_q != StCommit);
  assign xfer     = in_valid && in_ready;

  frame_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (xfer || (state_q == StIdle)),
    .enable_i ((state_q == StLoad) || (state_q == StCheck)),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    back_d  = back_q;
    front_d = front_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      StIdle: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d = StLoad;
          idx_d   = '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad: begin
        // A transfer beats a simultaneous timeout expiry.
        if (xfer) begin
          back_d[idx_q] = in_data;
          idx_d         = idx_q + 6'd1;
`ifdef FRAME_LOADER_CHECKSUM_EN
          sum_d         = sum_q + in_data;
          if (idx_q == 6'd63) state_d = StCheck;
`else
          if (idx_q == 6'd63) state_d = StCommit;
`endif
        end else if (expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StCheck: begin
`ifdef FRAME_LOADER_CHECKSUM_EN
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = StCommit;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else if (expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StCommit: begin
        front_d = back_q;
        cnt_d   = cnt_q + 8'd1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      back_q  <= '{default: '0};
      front_q <= '{default: '0};
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      back_q  <= back_d;
      front_q <= front_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  for (genvar i = 0; i < FRAME_BYTES; i++) begin : g_flat
    assign frame_cube_flat[8*i +: 8] = front_q[i];
  end

  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader; expected commits are queued as frames are sent.
// Honours FRAME_LOADER_CHECKSUM_EN by appending a checksum byte to each frame.
module tb_frame_loader;
  import lightcube_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] frame_cube_flat;
  logic         frame_done;
  logic         frame_err;
  logic [7:0]   frame_cnt;

  always #5 clk = ~clk;

  frame_loader #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .frame_cube_flat(frame_cube_flat),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .frame_cnt      (frame_cnt)
  );

  typedef struct packed {
    logic [511:0] flat;
    logic [7:0]   cnt;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  exp_t         push_e;
  logic [7:0]   frame_buf[64];
  logic [511:0] last_flat = '0;
  logic [7:0]   model_cnt = 8'd0;
  int           err_seen = 0;
  int           ready_low = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pack_buf();
    logic [511:0] f;
    for (int i = 0; i < 64; i++) f[8*i +: 8] = frame_buf[i];
    return f;
  endfunction

  function automatic logic [7:0] buf_sum();
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 64; i++) s = s + frame_buf[i];
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) ready_low++;
      if (frame_err) err_seen++;
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", frame_done, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("frame_flat", frame_cube_flat, mon_e.flat);
          check_eq("frame_cnt", frame_cnt, mon_e.cnt);
        end
      end
    end
  end

  // Called aligned to a negedge; returns aligned to the negedge after the transfer.
  task automatic put_byte(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_eq("ready_wait", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] csum, input bit expect_ok);
    if (expect_ok) begin
      model_cnt   = model_cnt + 8'd1;
      last_flat   = pack_buf();
      push_e.flat = last_flat;
      push_e.cnt  = model_cnt;
      exp_q.push_back(push_e);
    end
    put_byte(8'hA5);
    for (int i = 0; i < 64; i++) put_byte(frame_buf[i]);
`ifdef FRAME_LOADER_CHECKSUM_EN
    put_byte(csum);
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check_eq("commit_wait", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int e0;
    int guard;

    #12;
    check_eq("rst_flat", frame_cube_flat, '0);
    check_eq("rst_cnt", frame_cnt, 8'd0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_err", frame_err, 1'b0);
    check_eq("rst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", in_ready, 1'b1);

    // Ramp frame with valid held high throughout.
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i);
    r0 = ready_low;
    e0 = err_seen;
    send_frame(buf_sum(), 1'b1);
    wait_drain();
    check_eq("ramp_ready_low", ready_low - r0, 1);
    check_eq("ramp_no_err", err_seen - e0, 0);

    // Junk ahead of sync is dropped.
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(8'hFF - i);
    put_byte(8'h00);
    put_byte(8'h17);
    send_frame(buf_sum(), 1'b1);
    wait_drain();

    // Sync value inside data is ordinary payload.
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i * 3 + 7);
    frame_buf[10] = 8'hA5;
    frame_buf[11] = 8'hA5;
    send_frame(buf_sum(), 1'b1);
    wait_drain();

    // Timeout mid-frame leaves the committed frame intact.
    e0 = err_seen;
    put_byte(8'hA5);
    for (int i = 0; i < 20; i++) put_byte(8'h5A);
    in_valid = 1'b0;
    guard = 0;
    while (err_seen == e0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check_eq("timeout_err", err_seen - e0, 1);
    check_eq("timeout_flat", frame_cube_flat, last_flat);
    check_eq("timeout_cnt", frame_cnt, model_cnt);
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(8'h40 + i);
    send_frame(buf_sum(), 1'b1);
    wait_drain();

`ifdef FRAME_LOADER_CHECKSUM_EN
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'h01;
    send_frame(8'h40, 1'b1);
    wait_drain();
    e0 = err_seen;
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'h02;
    send_frame(8'h41, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("csum_err", err_seen - e0, 1);
    check_eq("csum_cnt", frame_cnt, model_cnt);
    check_eq("csum_flat", frame_cube_flat, last_flat);
`endif

    // Asynchronous reset mid-load after 30 data bytes.
    put_byte(8'hA5);
    for (int i = 0; i < 30; i++) put_byte(8'(8'h80 + i));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_flat", frame_cube_flat, '0);
    check_eq("midrst_cnt", frame_cnt, 8'd0);
    check_eq("midrst_ready", in_ready, 1'b0);
    model_cnt = 8'd0;
    last_flat = '0;
    in_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(8'hC3 ^ i);
    send_frame(buf_sum(), 1'b1);
    wait_drain();
    check_eq("final_cnt", frame_cnt, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
